// File: rtl/super_pkg.sv
// -----------------------------------------------------------------------------
// super_pkg
//   Shared pipeline types for the EX stage and the front-end branch predictor.
//   ex_bp_info_t : update packet sent from EX to the predictor tables.
//   bp_res_t     : one resolved EX slot together with the prediction it carried.
//   seq_pc()     : fall-through PC of an instruction (compressed = 2 bytes).
// -----------------------------------------------------------------------------
package super_pkg;

    localparam int unsigned NUM_SLOTS = 2;

    // Predictor update packet; valid bits per slot, slot 0 is the older one.
    typedef struct packed {
        logic [1:0]  is_branch;
        logic [1:0]  is_jal;
        logic [1:0]  taken;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [31:0] target0;
        logic [31:0] target1;
    } ex_bp_info_t;

    // Resolved slot: static kind, prediction carried from IF, actual outcome.
    typedef struct packed {
        logic [31:0] pc;
        logic        is_branch;
        logic        is_jal;
        logic        is_comp;
        logic        ptaken;
        logic [31:0] ptarget;
        logic        taken;
        logic [31:0] target;
    } bp_res_t;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc, input logic is_comp);
        return pc + (is_comp ? 32'd2 : 32'd4);
    endfunction

endpackage

// File: rtl/bp_miss_detect.sv
// -----------------------------------------------------------------------------
// bp_miss_detect
//   Combinational check of one resolved slot against its prediction.
//   res_i        : resolved slot (kind, prediction, outcome)
//   miss_o       : prediction was wrong for this slot
//   correct_pc_o : PC fetch should have continued from after this slot
// -----------------------------------------------------------------------------
module bp_miss_detect
    import super_pkg::*;
(
    input  bp_res_t     res_i,
    output logic        miss_o,
    output logic [31:0] correct_pc_o
);

    always_comb begin
        miss_o = 1'b0;
        if (res_i.is_branch) begin
            // Target only matters when the branch really went.
            miss_o = (res_i.ptaken != res_i.taken) ||
                     (res_i.taken && (res_i.ptarget != res_i.target));
        end else if (res_i.is_jal) begin
            miss_o = !res_i.ptaken || (res_i.ptarget != res_i.target);
        end
    end

    // A jal always transfers control, even if the ALU left taken low.
    assign correct_pc_o = (res_i.taken || res_i.is_jal) ? res_i.target
                                                        : seq_pc(res_i.pc, res_i.is_comp);

endmodule

// File: rtl/bp_resolve_unit.sv
// -----------------------------------------------------------------------------
// bp_resolve_unit
//   EX-stage branch resolution: compares both EX slots with their predictions,
//   builds the registered predictor update packet, raises a held redirect on a
//   mispredict, generates the one-cycle table-init pulse and counts branches.
//
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   ex_valid_i[1:0]    : slot valid (slot 0 older)
//   ex_res0_i/ex_res1_i: resolved slot info
//   bp_flush_req_i     : request predictor-table flush
//   redirect_ack_i     : IF accepted the redirect
//   ex_bp_info_o       : registered update packet
//   ex_bp_init_o       : one-cycle table-init pulse
//   tbl_rst_val_o      : table init value (RstTarget)
//   redirect_req_o/pc_o: held mispredict redirect and correct next PC
//   ex_stall_o         : EX holds while a redirect is outstanding
//   br_cnt_o/miss_cnt_o: resolved branch+jal count, mispredict-cycle count
// -----------------------------------------------------------------------------
module bp_resolve_unit
    import super_pkg::*;
#(
    parameter logic [31:0] RstTarget = 32'h0,
    parameter int          CntW      = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [1:0]      ex_valid_i,
    input  bp_res_t         ex_res0_i,
    input  bp_res_t         ex_res1_i,
    input  logic            bp_flush_req_i,
    input  logic            redirect_ack_i,
    output ex_bp_info_t     ex_bp_info_o,
    output logic            ex_bp_init_o,
    output logic [31:0]     tbl_rst_val_o,
    output logic            redirect_req_o,
    output logic [31:0]     redirect_pc_o,
    output logic            ex_stall_o,
    output logic [CntW-1:0] br_cnt_o,
    output logic [CntW-1:0] miss_cnt_o
);

    typedef enum logic {R_IDLE, R_WAIT}  redir_state_e;
    typedef enum logic {I_IDLE, I_PULSE} init_state_e;

    redir_state_e    redir_state_reg;
    init_state_e     init_state_reg;
    logic            redirect_req_reg;
    logic [31:0]     redirect_pc_reg;
    logic            init_pulse_reg;
    ex_bp_info_t     info_reg;
    ex_bp_info_t     info_next;
    logic [CntW-1:0] br_cnt_reg;
    logic [CntW-1:0] miss_cnt_reg;

    bp_res_t         res       [NUM_SLOTS];
    logic [31:0]     corr_pc   [NUM_SLOTS];
    logic [1:0]      miss;
    logic [1:0]      eff;
    logic [1:0]      eff_miss;
    logic [1:0]      upd_branch;
    logic [1:0]      upd_jal;
    logic [1:0]      upd_taken;
    logic [1:0]      counted;
    logic [1:0]      br_inc;
    logic            any_miss;
    logic [31:0]     miss_pc;
    logic            stall;
    logic            init_fire;

    assign res[0] = ex_res0_i;
    assign res[1] = ex_res1_i;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            bp_miss_detect u_miss_detect (
                .res_i        (res[gi]),
                .miss_o       (miss[gi]),
                .correct_pc_o (corr_pc[gi])
            );

            assign upd_branch[gi] = eff[gi] & res[gi].is_branch;
            assign upd_jal[gi]    = eff[gi] & res[gi].is_jal;
            // jal updates always train the entry as taken.
            assign upd_taken[gi]  = res[gi].taken | res[gi].is_jal;
            assign counted[gi]    = upd_branch[gi] | upd_jal[gi];
            assign eff_miss[gi]   = eff[gi] & miss[gi];
        end
    endgenerate

    assign stall  = (redir_state_reg == R_WAIT);
    assign eff[0] = ex_valid_i[0] & ~stall;
    // An older mispredict squashes the younger slot.
    assign eff[1] = ex_valid_i[1] & ~stall & ~(eff[0] & miss[0]);

    assign any_miss  = |eff_miss;
    assign miss_pc   = eff_miss[0] ? corr_pc[0] : corr_pc[1];
    assign init_fire = (init_state_reg == I_IDLE) & bp_flush_req_i;
    assign br_inc    = {1'b0, counted[0]} + {1'b0, counted[1]};

    always_comb begin
        info_next           = '0;
        info_next.taken     = upd_taken;
        info_next.pc0       = ex_res0_i.pc;
        info_next.pc1       = ex_res1_i.pc;
        info_next.target0   = ex_res0_i.target;
        info_next.target1   = ex_res1_i.target;
        // A table init in flight must not be followed by a stale training write.
        if (!init_fire) begin
            info_next.is_branch = upd_branch;
            info_next.is_jal    = upd_jal;
        end
    end

    // Redirect FSM with registered request/PC.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            redir_state_reg  <= R_IDLE;
            redirect_req_reg <= 1'b0;
            redirect_pc_reg  <= 32'h0;
        end else begin
            case (redir_state_reg)
                R_IDLE: begin
                    if (any_miss) begin
                        redir_state_reg  <= R_WAIT;
                        redirect_req_reg <= 1'b1;
                        redirect_pc_reg  <= miss_pc;
                    end
                end
                R_WAIT: begin
                    if (redirect_ack_i) begin
                        redir_state_reg  <= R_IDLE;
                        redirect_req_reg <= 1'b0;
                    end
                end
                default: begin
                    redir_state_reg  <= R_IDLE;
                    redirect_req_reg <= 1'b0;
                end
            endcase
        end
    end

    // Init FSM: the mandatory return to I_IDLE drops requests during the pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_state_reg <= I_IDLE;
            init_pulse_reg <= 1'b0;
        end else begin
            case (init_state_reg)
                I_IDLE: begin
                    if (bp_flush_req_i) begin
                        init_state_reg <= I_PULSE;
                        init_pulse_reg <= 1'b1;
                    end
                end
                default: begin
                    init_state_reg <= I_IDLE;
                    init_pulse_reg <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            info_reg     <= '0;
            br_cnt_reg   <= '0;
            miss_cnt_reg <= '0;
        end else begin
            info_reg     <= info_next;
            br_cnt_reg   <= br_cnt_reg + CntW'(br_inc);
            miss_cnt_reg <= miss_cnt_reg + CntW'(any_miss);
        end
    end

    assign ex_bp_info_o   = info_reg;
    assign ex_bp_init_o   = init_pulse_reg;
    assign tbl_rst_val_o  = RstTarget;
    assign redirect_req_o = redirect_req_reg;
    assign redirect_pc_o  = redirect_pc_reg;
    assign ex_stall_o     = stall;
    assign br_cnt_o       = br_cnt_reg;
    assign miss_cnt_o     = miss_cnt_reg;

endmodule

// File: tb/tb_bp_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_bp_resolve_unit
//   Scoreboard bench: the driver applies one cycle of stimulus at each falling
//   edge, runs the reference model and queues the expected post-edge outputs;
//   the monitor pops one entry after every rising edge and compares.
// -----------------------------------------------------------------------------
module tb_bp_resolve_unit;
    import super_pkg::*;

    localparam logic [31:0] RST_T = 32'h0000_1000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic [1:0]  ex_valid_i = 2'b00;
    bp_res_t     ex_res0_i = '0;
    bp_res_t     ex_res1_i = '0;
    logic        bp_flush_req_i = 1'b0;
    logic        redirect_ack_i = 1'b0;
    ex_bp_info_t ex_bp_info_o;
    logic        ex_bp_init_o;
    logic [31:0] tbl_rst_val_o;
    logic        redirect_req_o;
    logic [31:0] redirect_pc_o;
    logic        ex_stall_o;
    logic [31:0] br_cnt_o;
    logic [31:0] miss_cnt_o;

    bp_resolve_unit #(.RstTarget(RST_T), .CntW(32)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .ex_valid_i     (ex_valid_i),
        .ex_res0_i      (ex_res0_i),
        .ex_res1_i      (ex_res1_i),
        .bp_flush_req_i (bp_flush_req_i),
        .redirect_ack_i (redirect_ack_i),
        .ex_bp_info_o   (ex_bp_info_o),
        .ex_bp_init_o   (ex_bp_init_o),
        .tbl_rst_val_o  (tbl_rst_val_o),
        .redirect_req_o (redirect_req_o),
        .redirect_pc_o  (redirect_pc_o),
        .ex_stall_o     (ex_stall_o),
        .br_cnt_o       (br_cnt_o),
        .miss_cnt_o     (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  is_branch;
        logic [1:0]  is_jal;
        logic [1:0]  taken;
        logic [31:0] pc0, pc1, target0, target1;
        logic        init;
        logic        req;
        logic [31:0] rpc;
        logic [31:0] br;
        logic [31:0] miss;
        int          id;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    // Reference state: outstanding redirect, its PC, pulse in flight, counts.
    bit          m_pend;
    logic [31:0] m_rpc;
    bit          m_init;
    logic [31:0] m_br;
    logic [31:0] m_miss;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bp_res_t mk(input logic [31:0] pc, input bit br, input bit jal,
                                   input bit comp, input bit ptk, input logic [31:0] ptgt,
                                   input bit tk, input logic [31:0] tgt);
        bp_res_t r;
        r.pc = pc; r.is_branch = br; r.is_jal = jal; r.is_comp = comp;
        r.ptaken = ptk; r.ptarget = ptgt; r.taken = tk; r.target = tgt;
        return r;
    endfunction

    // Was the prediction wrong? Straight from the resolution rules.
    function automatic bit ref_miss(input bp_res_t r);
        if (r.is_branch) begin
            if (r.ptaken != r.taken) return 1;
            return r.taken && (r.ptarget != r.target);
        end
        if (r.is_jal) return !r.ptaken || (r.ptarget != r.target);
        return 0;
    endfunction

    function automatic logic [31:0] ref_next(input bp_res_t r);
        if (r.taken) return r.target;
        return r.pc + (r.is_comp ? 32'd2 : 32'd4);
    endfunction

    function automatic bp_res_t rand_res();
        bp_res_t r;
        int kind = $urandom_range(0, 3);
        r.pc        = $urandom & 32'hFFFF_FFFE;
        r.is_comp   = 1'($urandom);
        r.is_branch = (kind == 1) || (kind == 3);
        r.is_jal    = (kind == 2);
        r.target    = $urandom & 32'hFFFF_FFFE;
        r.taken     = r.is_jal ? 1'b1 : 1'($urandom);
        r.ptaken    = ($urandom_range(0, 3) != 0) ? r.taken : ~r.taken;
        r.ptarget   = ($urandom_range(0, 3) != 0) ? r.target : ($urandom & 32'hFFFF_FFFE);
        return r;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_rpc = 0; m_init = 0; m_br = 0; m_miss = 0;
    endtask

    task automatic drive(input logic [1:0] v, input bp_res_t r0, input bp_res_t r1,
                         input bit flush, input bit ack);
        exp_t e;
        bit   e0, e1, x0, x1, fire;
        @(negedge clk_i);
        ex_valid_i = v; ex_res0_i = r0; ex_res1_i = r1;
        bp_flush_req_i = flush; redirect_ack_i = ack;

        e0 = v[0] && !m_pend;
        x0 = e0 && ref_miss(r0);
        e1 = v[1] && !m_pend && !x0;
        x1 = e1 && ref_miss(r1);
        fire = flush && !m_init;

        e.is_branch = fire ? 2'b00 : {e1 && r1.is_branch, e0 && r0.is_branch};
        e.is_jal    = fire ? 2'b00 : {e1 && r1.is_jal, e0 && r0.is_jal};
        e.taken     = {r1.taken || r1.is_jal, r0.taken || r0.is_jal};
        e.pc0 = r0.pc; e.pc1 = r1.pc; e.target0 = r0.target; e.target1 = r1.target;

        m_br = m_br + 32'(int'(e0 && (r0.is_branch || r0.is_jal)))
                    + 32'(int'(e1 && (r1.is_branch || r1.is_jal)));
        if (x0 || x1) m_miss = m_miss + 1;
        if (m_pend) begin
            if (ack) m_pend = 0;
        end else if (x0 || x1) begin
            m_pend = 1;
            m_rpc  = x0 ? ref_next(r0) : ref_next(r1);
        end
        m_init = fire;

        e.init = m_init; e.req = m_pend; e.rpc = m_rpc;
        e.br = m_br; e.miss = m_miss; e.id = n_txn++;
        q.push_back(e);
    endtask

    // Monitor: every rising edge retires one queued expectation.
    initial begin
        exp_t e;
        logic [1:0] vm;
        forever begin
            @(posedge clk_i);
            #1;
            if (q.size() > 0) begin
                e  = q.pop_front();
                vm = ex_bp_info_o.is_branch | ex_bp_info_o.is_jal;
                chk("is_branch", 32'(ex_bp_info_o.is_branch), 32'(e.is_branch));
                chk("is_jal",    32'(ex_bp_info_o.is_jal),    32'(e.is_jal));
                chk("taken",     32'(ex_bp_info_o.taken & (e.is_branch | e.is_jal)),
                                 32'(e.taken & (e.is_branch | e.is_jal)));
                chk("pc0",       ex_bp_info_o.pc0,     e.pc0);
                chk("pc1",       ex_bp_info_o.pc1,     e.pc1);
                chk("target0",   ex_bp_info_o.target0, e.target0);
                chk("target1",   ex_bp_info_o.target1, e.target1);
                chk("init",      32'(ex_bp_init_o),    32'(e.init));
                chk("rst_val",   tbl_rst_val_o,        RST_T);
                chk("req",       32'(redirect_req_o),  32'(e.req));
                chk("stall",     32'(ex_stall_o),      32'(e.req));
                if (e.req) chk("redirect_pc", redirect_pc_o, e.rpc);
                chk("br_cnt",    br_cnt_o,             e.br);
                chk("miss_cnt",  miss_cnt_o,           e.miss);
                $display("txn %0d: valid=%b/%b req=%b rpc=%08h init=%b br=%0d miss=%0d",
                         e.id, ex_bp_info_o.is_branch, ex_bp_info_o.is_jal, redirect_req_o,
                         redirect_pc_o, ex_bp_init_o, br_cnt_o, miss_cnt_o);
                if (vm != (e.is_branch | e.is_jal)) begin end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drain();
        @(negedge clk_i);
        ex_valid_i = 2'b00; bp_flush_req_i = 0; redirect_ack_i = 0;
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        bp_res_t nop, good, bad;
        model_reset();
        #2 rst_ni = 1'b0;
        #1;
        chk("reset_req",     32'(redirect_req_o),     0);
        chk("reset_init",    32'(ex_bp_init_o),       0);
        chk("reset_rst_val", tbl_rst_val_o,           RST_T);
        chk("reset_br",      br_cnt_o,                0);
        chk("reset_valid",   32'({ex_bp_info_o.is_branch, ex_bp_info_o.is_jal}), 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        nop  = mk(32'h0000_0050, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        good = mk(32'h0000_0100, 1, 0, 0, 1, 32'h140, 1, 32'h140);

        // Correctly predicted taken branch.
        drive(2'b01, good, nop, 0, 0);
        // Predicted-taken compressed branch not taken; younger jal squashed.
        bad = mk(32'h0000_0200, 1, 0, 1, 1, 32'h240, 0, 32'h240);
        drive(2'b11, bad, mk(32'h202, 0, 1, 0, 1, 32'h300, 1, 32'h300), 0, 0);
        // Held redirect with both slots offered; nothing is accepted.
        repeat (5) drive(2'b11, good, good, 0, 0);
        drive(2'b11, good, good, 0, 1);
        drive(2'b01, good, nop, 0, 0);
        // Mispredict in slot 1 only.
        drive(2'b11, nop, mk(32'h300, 0, 1, 0, 0, 32'h0, 1, 32'h400), 0, 0);
        drive(2'b00, nop, nop, 0, 1);
        // Flush coinciding with a valid branch, then a held flush level.
        drive(2'b01, good, nop, 1, 0);
        drive(2'b01, good, nop, 1, 0);
        drive(2'b01, good, nop, 1, 0);
        drive(2'b00, nop, nop, 0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom), rand_res(), rand_res(),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
        end
        drain();

        // Reset while a redirect is outstanding.
        bad = mk(32'h0000_0400, 1, 0, 0, 0, 32'h0, 1, 32'h480);
        drive(2'b01, bad, nop, 0, 0);
        drive(2'b00, nop, nop, 0, 0);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_req",   32'(redirect_req_o), 0);
        chk("async_rst_stall", 32'(ex_stall_o),     0);
        chk("async_rst_br",    br_cnt_o,            0);
        chk("async_rst_miss",  miss_cnt_o,          0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();

        for (int i = 0; i < 40; i++) begin
            drive(2'($urandom), rand_res(), rand_res(),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
        end
        drain();
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_resolve_unit.md
# bp_resolve_unit

EX-stage branch resolution unit that checks each resolved branch or jump against the prediction it carried down the pipe. Drives three outputs: the registered `ex_bp_info_t` update packet consumed by the front-end branch predictor, the `ex_bp_init` table-flush pulse, and a held mispredict redirect toward IF. Sits at the end of EX, between the two ALU/branch slots and the fetch/predict logic. Also keeps branch and mispredict counters.

## Interface
Parameters:
- `RstTarget`, 32'h0: value driven on `tbl_rst_val_o` during table init.
- `CntW`, 32: width of the performance counters.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `ex_valid_i` in 2: slot valid; slot 0 is older.
- `ex_res0_i`, `ex_res1_i` in `bp_res_t`: resolved slot info.
  - Fields: `pc`, `is_branch`, `is_jal`, `is_comp`, `ptaken`, `ptarget`, `taken`, `target`.
- `bp_flush_req_i` in 1: request a predictor-table flush (fence.i, or a `pdt_en` change).
- `redirect_ack_i` in 1: IF accepted the redirect.
- `ex_bp_info_o` out `ex_bp_info_t`: update packet to the predictor.
- `ex_bp_init_o` out 1: one-cycle table-init pulse.
- `tbl_rst_val_o` out 32: constant `RstTarget`.
- `redirect_req_o` out 1: mispredict redirect pending.
- `redirect_pc_o` out 32: correct next PC.
- `ex_stall_o` out 1: EX must hold; no new slots are accepted.
- `br_cnt_o` out `CntW`: resolved branch and jal count.
- `miss_cnt_o` out `CntW`: mispredict count.

## Operation
- **Per-slot mispredict `miss[k]`:**
  - Branch: `ptaken != taken`, or `taken && ptarget != target`.
  - jal: `!ptaken`, or `ptarget != target`.
  - All other instructions: 0.
- **Effective slots:**
  - `eff[0] = ex_valid_i[0] & ~ex_stall_o`.
  - `eff[1] = ex_valid_i[1] & ~ex_stall_o & ~(eff[0] & miss[0])`. A slot-0 mispredict squashes slot 1.
- **Correct PC:** `taken ? target : pc + (is_comp ? 2 : 4)`, computed mod 2^32. Taken from the oldest mispredicting effective slot.
- **Update packet**, registered every cycle:
  - `is_branch[k] = eff[k] & is_branch`; `is_jal[k] = eff[k] & is_jal`; `taken[k]` copied.
  - `pc0`/`pc1` and `target0`/`target1` copied.
  - `is_jal` updates carry `taken=1`.
  - Squashed and invalid slots drive zero valid bits.
- **Redirect FSM**, states R_IDLE and R_WAIT:
  - R_IDLE to R_WAIT when any effective slot mispredicts. Latch `redirect_pc_o`.
  - R_WAIT holds `redirect_req_o=1` and `redirect_pc_o` stable until `redirect_ack_i`, then returns to R_IDLE.
  - `ex_stall_o = (state==R_WAIT)`.
  - ack while in R_IDLE is ignored.
- **Init FSM**, states I_IDLE and I_PULSE:
  - `bp_flush_req_i` in I_IDLE moves to I_PULSE.
  - I_PULSE drives `ex_bp_init_o=1` for exactly one cycle, then returns to I_IDLE.
  - Requests while in I_PULSE are dropped. A held level request re-pulses every second cycle.
  - The packet registered in the same cycle as the pulse has all valid bits forced to 0 (init wins over update).
- **Counters:**
  - `br_cnt` adds `popcount(is_branch|is_jal over eff)`, 0..2.
  - `miss_cnt` adds 1 per cycle with any effective miss.
  - Both wrap modulo 2^CntW.

## Timing
- Reset values:
  - All outputs 0 except `tbl_rst_val_o = RstTarget`.
  - FSMs reset to R_IDLE and I_IDLE; counters reset to 0.
- Update packet, `redirect_req_o` and counters appear 1 cycle after the resolving `ex_valid_i` cycle.
- `ex_bp_init_o` is high the cycle after `bp_flush_req_i` is sampled.
- A redirect ack in the same cycle the request first appears gives a 1-cycle request. The FSM is in R_IDLE the next cycle and the next slots are accepted.
- A mispredict is never lost. While in R_WAIT nothing is effective, so no new miss can arise.
- Reset asserted mid-R_WAIT drops the request immediately (asynchronous).

## Structure
- `bp_res_t` is added to `super_pkg`, next to the existing `ex_bp_info_t`. `ex_bp_info_t` is unchanged.
- The FSM state enums stay local to this module.
- One combinational sub-module, `bp_miss_detect`, is instantiated per slot. It outputs `miss` and `correct_pc` from one `bp_res_t`.
- Expected size: about 200 lines of RTL.

## Test plan
- Correctly predicted branch:
  - Stimulus: slot0 branch at 0x100, ptaken=1, ptarget=0x140, taken=1, target=0x140.
  - Next cycle: `is_branch=2'b01`, `taken[0]=1`, `target0=0x140`, no redirect, `br_cnt=1`.
- Predicted-taken branch actually not taken:
  - Stimulus: slot0 at 0x200, is_comp=1, ptaken=1, taken=0; slot1 jal valid.
  - Required: `redirect_pc_o=0x202`; slot1 squashed, so `is_jal=2'b00`; `miss_cnt=1`; `ex_stall_o=1` until ack.
- Mispredict in slot 1 only:
  - Stimulus: slot0 non-branch; slot1 jal at 0x300, ptaken=0, target=0x400.
  - Required: `redirect_pc_o=0x400`, `is_jal=2'b10`.
- Held redirect:
  - Stimulus: hold ack low for 5 cycles while `ex_valid_i=2'b11`.
  - Required: `redirect_req_o` and `redirect_pc_o` stable; packet valid bits 0; counters frozen; release the cycle after ack.
- Flush colliding with an update:
  - Stimulus: `bp_flush_req_i` pulse in the same cycle as a valid branch.
  - Required: `ex_bp_init_o=1` for one cycle, `tbl_rst_val_o=RstTarget`, packet valid bits 0 that cycle.
- Reset during R_WAIT:
  - Stimulus: assert `rst_ni=0` while in R_WAIT.
  - Required: `redirect_req_o=0` asynchronously; counters reset to 0.
